// File: rtl/food_gen.sv
// food_gen -- places food for the snake game.
//
// A free-running 16-bit LFSR supplies candidate cells. A candidate that is
// off the 40x30 board or under the snake head is dropped at once; a legal
// one is offered to the body-occupancy logic through a request/acknowledge
// handshake. A free cell becomes the food. Eating the food (head moves onto
// it while running) pulses get_food and starts the next placement.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   game_state[1:0]       00 RUN, 01 PAUSE, 10 OVER, 11 behaves as PAUSE
//   head_x/head_y[5:0]    snake head cell; head_valid pulses on each move
//   cand_x/cand_y[5:0]    candidate cell under query; cand_req held until ack
//   occ_ack, occ_hit      occupancy answer pulse; hit = cell is snake body
//   food_x/food_y[5:0]    current food cell; food_valid = food present
//   get_food              one-cycle registered pulse per eaten food
module food_gen (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] game_state,
   input  logic [5:0] head_x,
   input  logic [5:0] head_y,
   input  logic       head_valid,
   output logic [5:0] cand_x,
   output logic [5:0] cand_y,
   output logic       cand_req,
   input  logic       occ_ack,
   input  logic       occ_hit,
   output logic [5:0] food_x,
   output logic [5:0] food_y,
   output logic       food_valid,
   output logic       get_food
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GEN    = 2'd1,
      CHECK  = 2'd2,
      ACTIVE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] lfsr;

   logic [5:0]  samp_x;
   logic [5:0]  samp_y;
   logic        is_run;
   logic        is_over;
   logic        samp_ok;
   logic        eat_match;

   logic        cand_load;
   logic        req_clear;
   logic        food_load;
   logic        eat;

   assign is_run  = (game_state == 2'b00);
   assign is_over = (game_state == 2'b10);

   assign samp_x  = lfsr[5:0];
   assign samp_y  = lfsr[13:8];
   assign samp_ok = (samp_x < 6'd40) && (samp_y < 6'd30) &&
                    !((samp_x == head_x) && (samp_y == head_y));

   // PAUSE (and 11) never qualifies a head move, so ACTIVE simply holds.
   assign eat_match = head_valid && is_run &&
                      (head_x == food_x) && (head_y == food_y);

   // x^16+x^14+x^13+x^11+1, right-shifting form; never stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= 16'hACE1;
      else
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // OVER dominates every state, including a coincident eat.
   always_comb begin
      state_next = state;
      if (is_over) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (is_run)    state_next = GEN;
            GEN:     if (samp_ok)   state_next = CHECK;
            CHECK:   if (occ_ack)   state_next = occ_hit ? GEN : ACTIVE;
            ACTIVE:  if (eat_match) state_next = GEN;
            default:                state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      cand_load = 1'b0;
      req_clear = 1'b0;
      food_load = 1'b0;
      eat       = 1'b0;
      if (!is_over) begin
         case (state)
            GEN:     cand_load = samp_ok;
            CHECK: begin
               req_clear = occ_ack;
               food_load = occ_ack && !occ_hit;
            end
            ACTIVE:  eat = eat_match;
            default: ;
         endcase
      end
   end

   // food_x/food_y are deliberately left untouched on OVER.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_x     <= '0;
         cand_y     <= '0;
         cand_req   <= 1'b0;
         food_x     <= '0;
         food_y     <= '0;
         food_valid <= 1'b0;
         get_food   <= 1'b0;
      end else begin
         get_food <= eat;
         if (is_over) begin
            cand_req   <= 1'b0;
            food_valid <= 1'b0;
         end else begin
            if (cand_load) begin
               cand_x   <= samp_x;
               cand_y   <= samp_y;
               cand_req <= 1'b1;
            end else if (req_clear) begin
               cand_req <= 1'b0;
            end
            if (food_load) begin
               food_x     <= cand_x;
               food_y     <= cand_y;
               food_valid <= 1'b1;
            end else if (eat) begin
               food_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_food_gen.sv
module tb_food_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] game_state;
   logic [5:0] head_x;
   logic [5:0] head_y;
   logic       head_valid;
   logic [5:0] cand_x;
   logic [5:0] cand_y;
   logic       cand_req;
   logic       occ_ack;
   logic       occ_hit;
   logic [5:0] food_x;
   logic [5:0] food_y;
   logic       food_valid;
   logic       get_food;

   always #5 clk = ~clk;

   food_gen dut (
      .clk        (clk),
      .rst        (rst),
      .game_state (game_state),
      .head_x     (head_x),
      .head_y     (head_y),
      .head_valid (head_valid),
      .cand_x     (cand_x),
      .cand_y     (cand_y),
      .cand_req   (cand_req),
      .occ_ack    (occ_ack),
      .occ_hit    (occ_hit),
      .food_x     (food_x),
      .food_y     (food_y),
      .food_valid (food_valid),
      .get_food   (get_food)
   );

   typedef struct packed {
      logic [5:0] x;
      logic [5:0] y;
   } cell_t;

   int    checks = 0;
   int    errors = 0;
   int    handshakes = 0;
   cell_t cand_q[$];
   cell_t food_q[$];
   int    eat_q[$];
   cell_t last_pred;
   cell_t cur_food;
   logic [15:0] m_lfsr;

   localparam logic [1:0] RUN   = 2'b00;
   localparam logic [1:0] PAUSE = 2'b01;
   localparam logic [1:0] OVER  = 2'b10;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference LFSR written as integer arithmetic on the polynomial taps.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      int unsigned u;
      int unsigned b;
      u = v;
      b = ((u >> 0) ^ (u >> 2) ^ (u >> 3) ^ (u >> 5)) & 1;
      return 16'((u >> 1) | (b << 15));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= lfsr_step(m_lfsr);
   end

   // First legal cell reachable from LFSR value l, one sample per cycle.
   function automatic cell_t predict(input logic [15:0] l, input logic [5:0] hx, input logic [5:0] hy);
      logic [15:0] v;
      cell_t r;
      v = l;
      for (int i = 0; i < 70000; i++) begin
         if (v[5:0] < 6'd40 && v[13:8] < 6'd30 && !(v[5:0] == hx && v[13:8] == hy)) begin
            r.x = v[5:0];
            r.y = v[13:8];
            return r;
         end
         v = lfsr_step(v);
      end
      r.x = 6'h3F;
      r.y = 6'h3F;
      return r;
   endfunction

   // Called just after the edge on which the DUT enters GEN.
   task automatic push_pred();
      last_pred = predict(m_lfsr, head_x, head_y);
      cand_q.push_back(last_pred);
   endtask

   // Monitor: compares each new request, new food and eat pulse against the queues.
   logic prev_req = 1'b0;
   logic prev_fv  = 1'b0;
   always @(negedge clk) begin
      cell_t e;
      if (rst) begin
         prev_req = 1'b0;
         prev_fv  = 1'b0;
      end else begin
         if (cand_req && !prev_req) begin
            handshakes++;
            check("cand_x_range", 32'(cand_x < 6'd40), 32'd1);
            check("cand_y_range", 32'(cand_y < 6'd30), 32'd1);
            if (cand_q.size() == 0) check("cand_unexpected", 32'(cand_req), 32'd0);
            else begin
               e = cand_q.pop_front();
               check("cand_x", 32'(cand_x), 32'(e.x));
               check("cand_y", 32'(cand_y), 32'(e.y));
            end
         end
         if (food_valid && !prev_fv) begin
            if (food_q.size() == 0) check("food_unexpected", 32'(food_valid), 32'd0);
            else begin
               e = food_q.pop_front();
               check("food_x", 32'(food_x), 32'(e.x));
               check("food_y", 32'(food_y), 32'(e.y));
            end
         end
         if (get_food) begin
            if (eat_q.size() == 0) check("get_food_unexpected", 32'(get_food), 32'd0);
            else begin
               void'(eat_q.pop_front());
               check("food_valid_at_eat", 32'(food_valid), 32'd0);
            end
         end
         prev_req = cand_req;
         prev_fv  = food_valid;
      end
   end

   // Occupancy responder: answers one cycle after the request is seen.
   task automatic handshake(input logic hit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cand_req && n < 300);
      if (!cand_req) begin
         check("cand_req_timeout", 32'(cand_req), 32'd1);
         return;
      end
      @(negedge clk);
      check("cand_req_held", 32'(cand_req), 32'd1);
      check("cand_x_stable", 32'(cand_x), 32'(last_pred.x));
      check("cand_y_stable", 32'(cand_y), 32'(last_pred.y));
      occ_ack = 1'b1;
      occ_hit = hit;
      if (!hit) begin
         food_q.push_back(last_pred);
         cur_food = last_pred;
      end
      @(posedge clk);
      #1;
      if (hit) push_pred();
      @(negedge clk);
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      check("cand_req_dropped", 32'(cand_req), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      rst        = 1'b1;
      game_state = PAUSE;
      head_x     = 6'd5;
      head_y     = 6'd5;
      head_valid = 1'b0;
      occ_ack    = 1'b0;
      occ_hit    = 1'b0;
      cur_food   = '0;
      last_pred  = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_cand_req", 32'(cand_req), 32'd0);
      check("rst_cand_x", 32'(cand_x), 32'd0);
      check("rst_cand_y", 32'(cand_y), 32'd0);
      check("rst_food_x", 32'(food_x), 32'd0);
      check("rst_food_y", 32'(food_y), 32'd0);
      check("rst_food_valid", 32'(food_valid), 32'd0);
      check("rst_get_food", 32'(get_food), 32'd0);
      check("rst_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
      rst = 1'b0;

      // PAUSE in IDLE does not start placement
      repeat (3) @(negedge clk);
      check("idle_pause_req", 32'(cand_req), 32'd0);

      // Two occupied answers, then a free one: three handshakes
      game_state = RUN;
      hs0 = handshakes;
      @(posedge clk);
      #1 push_pred();
      handshake(1'b1);
      check("food_valid_after_hit1", 32'(food_valid), 32'd0);
      handshake(1'b1);
      check("food_valid_after_hit2", 32'(food_valid), 32'd0);
      handshake(1'b0);
      @(negedge clk);
      check("handshake_count", 32'(handshakes - hs0), 32'd3);
      check("food_valid_placed", 32'(food_valid), 32'd1);
      check("food_x_third", 32'(food_x), 32'(cur_food.x));
      check("food_y_third", 32'(food_y), 32'(cur_food.y));

      // Stray occupancy answer while ACTIVE is ignored
      occ_ack = 1'b1;
      occ_hit = 1'b0;
      @(negedge clk);
      occ_ack = 1'b0;
      @(negedge clk);
      check("stray_ack_req", 32'(cand_req), 32'd0);
      check("stray_ack_fv", 32'(food_valid), 32'd1);

      // Head onto food while paused: no eat
      game_state = PAUSE;
      head_x     = cur_food.x;
      head_y     = cur_food.y;
      head_valid = 1'b1;
      @(negedge clk);
      head_valid = 1'b0;
      check("pause_get_food", 32'(get_food), 32'd0);
      check("pause_food_valid", 32'(food_valid), 32'd1);
      @(negedge clk);
      check("pause_no_req", 32'(cand_req), 32'd0);

      // Head onto food while running: one eat pulse, then new placement
      game_state = RUN;
      head_valid = 1'b1;
      eat_q.push_back(1);
      @(posedge clk);
      #1 push_pred();
      @(negedge clk);
      head_valid = 1'b0;
      check("eat_get_food", 32'(get_food), 32'd1);
      check("eat_food_valid", 32'(food_valid), 32'd0);
      @(negedge clk);
      check("eat_pulse_one_cycle", 32'(get_food), 32'd0);
      handshake(1'b0);
      @(negedge clk);
      check("replaced_food_valid", 32'(food_valid), 32'd1);

      // OVER coincides with an eat match: OVER wins
      head_x     = cur_food.x;
      head_y     = cur_food.y;
      head_valid = 1'b1;
      game_state = OVER;
      @(negedge clk);
      head_valid = 1'b0;
      check("over_get_food", 32'(get_food), 32'd0);
      check("over_food_valid", 32'(food_valid), 32'd0);
      check("over_cand_req", 32'(cand_req), 32'd0);
      check("over_food_x_held", 32'(food_x), 32'(cur_food.x));
      check("over_food_y_held", 32'(food_y), 32'(cur_food.y));
      repeat (2) @(negedge clk);
      check("over_idle_req", 32'(cand_req), 32'd0);
      game_state = RUN;
      @(posedge clk);
      #1 push_pred();
      handshake(1'b0);

      // Eat again, then reset while the next request is outstanding
      @(negedge clk);
      head_x     = cur_food.x;
      head_y     = cur_food.y;
      head_valid = 1'b1;
      eat_q.push_back(1);
      @(posedge clk);
      #1 push_pred();
      @(negedge clk);
      head_valid = 1'b0;
      begin
         int n;
         n = 0;
         while (!cand_req && n < 300) begin
            @(negedge clk);
            n++;
         end
      end
      check("pre_reset_req", 32'(cand_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_cand_req", 32'(cand_req), 32'd0);
      check("async_cand_x", 32'(cand_x), 32'd0);
      check("async_cand_y", 32'(cand_y), 32'd0);
      check("async_food_x", 32'(food_x), 32'd0);
      check("async_food_y", 32'(food_y), 32'd0);
      check("async_food_valid", 32'(food_valid), 32'd0);
      check("async_get_food", 32'(get_food), 32'd0);
      check("async_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 push_pred();
      handshake(1'b0);
      repeat (3) @(negedge clk);

      check("cand_q_empty", 32'(cand_q.size()), 32'd0);
      check("food_q_empty", 32'(food_q.size()), 32'd0);
      check("eat_q_empty", 32'(eat_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/food_gen.md
FOOD_GEN -- requirements
Module: food_gen

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: game_state  input  2  00=RUN, 01=PAUSE, 10=OVER, 11=treated as PAUSE.
REQ-004 SHALL have port: head_x  input  6  snake head column, 0..39.
REQ-005 SHALL have port: head_y  input  6  snake head row, 0..29.
REQ-006 SHALL have port: head_valid  input  1  one-cycle pulse; head moved to (head_x, head_y).
REQ-007 SHALL have port: cand_x  output  6  candidate food column under occupancy query.
REQ-008 SHALL have port: cand_y  output  6  candidate food row under occupancy query.
REQ-009 SHALL have port: cand_req  output  1  occupancy query request; held until acknowledged.
REQ-010 SHALL have port: occ_ack  input  1  occupancy answer valid; one-cycle pulse.
REQ-011 SHALL have port: occ_hit  input  1  candidate cell occupied by snake body; qualified by occ_ack.
REQ-012 SHALL have port: food_x  output  6  current food column.
REQ-013 SHALL have port: food_y  output  6  current food row.
REQ-014 SHALL have port: food_valid  output  1  food present at (food_x, food_y).
REQ-015 SHALL have port: get_food  output  1  registered one-cycle pulse; food eaten; feeds the score counter.

Function
REQ-016 SHALL contain a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every clock in every state; only rst reloads it.
REQ-017 SHALL use FSM states IDLE, GEN, CHECK, ACTIVE.
REQ-018 IDLE: food_valid=0, cand_req=0; SHALL go to GEN on the first cycle game_state==RUN.
REQ-019 GEN: SHALL sample candidate x=lfsr[5:0], y=lfsr[13:8]; one sample per cycle.
REQ-020 GEN: SHALL reject a candidate with x>=40, y>=30 or (x,y)==(head_x,head_y) and stay in GEN; otherwise register cand_x/cand_y, set cand_req=1, go to CHECK.
REQ-021 CHECK: cand_x, cand_y, cand_req SHALL stay stable until the cycle occ_ack=1; no timeout.
REQ-022 CHECK on occ_ack with occ_hit=1: SHALL drop cand_req and return to GEN.
REQ-023 CHECK on occ_ack with occ_hit=0: SHALL drop cand_req, load food_x/food_y from cand_x/cand_y, set food_valid=1 next cycle, go to ACTIVE.
REQ-024 ACTIVE: a cycle with head_valid=1, game_state==RUN and (head_x,head_y)==(food_x,food_y) SHALL make get_food=1 and food_valid=0 on the next cycle, then go to GEN.
REQ-025 get_food SHALL be high for exactly one cycle per eaten food and never in any other case.
REQ-026 PAUSE: ACTIVE SHALL hold and ignore head_valid; GEN and CHECK SHALL continue so placement completes.
REQ-027 OVER in any state SHALL go to IDLE next cycle and clear food_valid, cand_req and get_food; food_x/food_y hold their values.
REQ-028 OVER with a simultaneous eat match SHALL win: no get_food pulse.
REQ-029 occ_ack outside CHECK SHALL be ignored.

Reset
REQ-030 rst=1 SHALL force, asynchronously: state=IDLE, lfsr=16'hACE1, food_x=0, food_y=0, food_valid=0, get_food=0, cand_req=0, cand_x=0, cand_y=0.
REQ-031 rst asserted mid-CHECK SHALL drop cand_req immediately; no food is committed.

Verification
REQ-032 Reset, then game_state=RUN with a responder that acks 1 cycle after cand_req with hit=0 -> cand_x<40, cand_y<30 on every request; food_valid=1 with food equal to the last candidate.
REQ-033 Responder answers hit=1 twice, then hit=0 -> exactly 3 cand_req handshakes; food equals the third candidate; food_valid stays 0 until then.
REQ-034 Food at (12,7); head_valid with head (12,7), RUN -> get_food=1 for exactly one cycle; food_valid=0 the same cycle; a new cand_req follows.
REQ-035 Same match with game_state=PAUSE -> no get_food; food_valid stays 1.
REQ-036 Match cycle coincides with game_state=OVER -> no get_food; IDLE next cycle; food_valid=0; after RUN returns, a new placement starts.
REQ-037 rst pulsed while cand_req=1 -> all outputs at reset values; lfsr=16'hACE1.
